// File: rtl/compressed_mem_reader.sv
`default_nettype none
// ============================================================================
// Module      : compressed_mem_reader
// Description : Burst read engine for the 16x8 compressed memory. Takes a
//               burst request, issues credit-limited reads and rebuilds each
//               word's low byte from a fill value. Words are delivered on a
//               valid/ready stream through a 4-entry first-word-fall-through
//               buffer, so downstream backpressure never loses a word.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               req_*              - burst request (addr, len 0..16, round)
//               rd_en/rd_addr      - memory read port (issue side)
//               rd_data            - memory data, valid one cycle after rd_en
//               out_valid/ready    - decompressed output stream
//               out_data/out_last  - word and end-of-burst marker
//               done               - one-cycle pulse after burst completes
// Revision    : 1.0 - initial release
// ============================================================================
module compressed_mem_reader #(
    parameter int BW  = 16,
    parameter int CBW = 8,
    parameter int AW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [AW:0]   req_len,
    input  logic          req_round,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [BW-1:0] rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic          out_last,
    output logic          done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int DEPTH = 4;

    localparam logic [AW:0]       C_ONE_LEN    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0]     C_ONE_ADDR   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [BW-CBW-1:0] C_FILL_ROUND = {1'b1, {(BW-CBW-1){1'b0}}};
    localparam logic [BW-CBW-1:0] C_FILL_ZERO  = '0;

    // Control state
    logic [1:0]    state_q,      state_d;
    logic [AW-1:0] cur_addr_q,   cur_addr_d;
    logic [AW:0]   issue_left_q, issue_left_d;
    logic [AW:0]   pop_left_q,   pop_left_d;
    logic          mode_q,       mode_d;
    logic          done_q,       done_d;
    logic          inflight_q;

    // Output buffer
    logic [BW-1:0] fifo_q [DEPTH];
    logic [1:0]    wr_ptr_q;
    logic [1:0]    rd_ptr_q;
    logic [2:0]    count_q;

    logic            w_credit;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic            w_last;
    logic [CBW-1:0]  w_hi;
    logic [BW-CBW-1:0] w_fill;
    logic [BW-1:0]   w_push_data;
    logic            w_unused_rd_lo;

    // The stored low byte is discarded and rebuilt from the fill rule.
    assign w_unused_rd_lo = ^rd_data[BW-CBW-1:0];

    // A read in flight has a reserved slot, so the buffer can never overflow.
    assign w_credit = ({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4;
    assign w_issue  = (state_q == S_ISSUE) && w_credit;

    assign w_valid  = (count_q != 3'd0);
    assign w_pop    = w_valid && out_ready;
    assign w_last   = w_valid && (pop_left_q == C_ONE_LEN);

    // rd_data is only meaningful the cycle after a sampled rd_en.
    assign w_push      = inflight_q;
    assign w_hi        = rd_data[BW-1:BW-CBW];
    assign w_fill      = (mode_q && (w_hi != '0)) ? C_FILL_ROUND : C_FILL_ZERO;
    assign w_push_data = {w_hi, w_fill};

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            mode_q       <= 1'b0;
            done_q       <= 1'b0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            mode_q       <= mode_d;
            done_q       <= done_d;
            inflight_q   <= w_issue;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        mode_d       = mode_q;
        done_d       = 1'b0;

        if (w_pop) begin
            pop_left_d = pop_left_q - C_ONE_LEN;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cur_addr_d   = req_addr;
                    issue_left_d = req_len;
                    pop_left_d   = req_len;
                    mode_d       = req_round;
                    if (req_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (w_issue) begin
                    // Address counter is AW bits wide, so 15 -> 0 wraps naturally.
                    cur_addr_d   = cur_addr_q + C_ONE_ADDR;
                    issue_left_d = issue_left_q - C_ONE_LEN;
                    if (issue_left_q == C_ONE_LEN) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && w_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rd_en     = w_issue;
        rd_addr   = cur_addr_q;
        done      = done_q;
        out_valid = w_valid;
        out_last  = w_last;
        out_data  = w_valid ? fifo_q[rd_ptr_q] : '0;
    end

    // ---------------------------------------------------------------- buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                fifo_q[wr_ptr_q] <= w_push_data;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire
